// File: rtl/rab_inval_pkg.sv
// Shared types and helpers for the RAB invalidation engine.
package rab_inval_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1_SCAN,
    ST_L2_SCAN,
    ST_DRAIN,
    ST_DONE
  } inval_state_e;

  localparam int PAGE_SHIFT = 12;
  localparam int MAX_AW     = 64;

  // Inclusive interval overlap; callers zero-extend so the compare stays unsigned.
  function automatic logic range_overlap(input logic [MAX_AW-1:0] entry_start,
                                         input logic [MAX_AW-1:0] entry_end,
                                         input logic [MAX_AW-1:0] range_start,
                                         input logic [MAX_AW-1:0] range_end);
    return (entry_start <= range_end) && (entry_end >= range_start);
  endfunction

endpackage

// File: rtl/rab_range_cmp.sv
// Combinational check: does a valid entry's VA interval overlap the request range.
module rab_range_cmp
  import rab_inval_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          vld,
  input  logic [AW-1:0] entry_start,
  input  logic [AW-1:0] entry_end,
  input  logic [AW-1:0] range_start,
  input  logic [AW-1:0] range_end,
  output logic          hit
);

  assign hit = vld && range_overlap(MAX_AW'(entry_start), MAX_AW'(entry_end),
                                    MAX_AW'(range_start), MAX_AW'(range_end));

endmodule

// File: rtl/rab_inval_ctrl.sv
// RAB invalidation engine: sweeps all L1 slices then all L2 entries and clears
// the valid bit of every entry overlapping the latched VA range.
module rab_inval_ctrl
  import rab_inval_pkg::*;
#(
  parameter  int AW               = 32,
  parameter  int N_SLICES         = 32,
  parameter  int L2_N_SETS        = 32,
  parameter  int L2_N_SET_ENTRIES = 32,
  localparam int L2_TOT           = L2_N_SETS * L2_N_SET_ENTRIES,
  localparam int L1_IW            = (N_SLICES > 1) ? $clog2(N_SLICES) : 1,
  localparam int L2_IW            = (L2_TOT > 1) ? $clog2(L2_TOT) : 1
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RI,
  input  logic                     InvReq_SI,
  input  logic [AW-1:0]            InvStart_DI,
  input  logic [AW-1:0]            InvEnd_DI,
  output logic                     Busy_SO,
  output logic                     Done_SO,
  output logic                     ReqErr_SO,
  output logic                     L1RdEn_SO,
  output logic [L1_IW-1:0]         L1RdIdx_DO,
  input  logic [AW-1:0]            L1RdStart_DI,
  input  logic [AW-1:0]            L1RdEnd_DI,
  input  logic                     L1RdValid_DI,
  output logic                     L1ClrEn_SO,
  output logic [L1_IW-1:0]         L1ClrIdx_DO,
  output logic                     L2RdEn_SO,
  input  logic                     L2Gnt_SI,
  output logic [L2_IW-1:0]         L2RdIdx_DO,
  input  logic [AW-PAGE_SHIFT-1:0] L2RdTag_DI,
  input  logic                     L2RdValid_DI,
  output logic                     L2ClrEn_SO,
  output logic [L2_IW-1:0]         L2ClrIdx_DO
);

  localparam logic [L1_IW-1:0] L1_LAST = L1_IW'(N_SLICES - 1);
  localparam logic [L2_IW-1:0] L2_LAST = L2_IW'(L2_TOT - 1);

  inval_state_e     state_q;
  logic [AW-1:0]    range_start_q, range_end_q;
  logic [L1_IW-1:0] l1_idx_q, l1_cmp_idx_q;
  logic [L2_IW-1:0] l2_idx_q, l2_cmp_idx_q;
  logic             l1_rd_en_q, l2_rd_en_q;
  logic             l1_cmp_vld_q, l2_cmp_vld_q;
  logic             busy_q, done_q, err_q;

  logic [AW-1:0]    l2_entry_start, l2_entry_end;
  logic             l1_hit, l2_hit;

  // A cleared L2 entry covers exactly one page.
  assign l2_entry_start = {L2RdTag_DI, {PAGE_SHIFT{1'b0}}};
  assign l2_entry_end   = {L2RdTag_DI, {PAGE_SHIFT{1'b1}}};

  rab_range_cmp #(.AW(AW)) u_l1_cmp (
    .vld         (l1_cmp_vld_q && L1RdValid_DI),
    .entry_start (L1RdStart_DI),
    .entry_end   (L1RdEnd_DI),
    .range_start (range_start_q),
    .range_end   (range_end_q),
    .hit         (l1_hit)
  );

  rab_range_cmp #(.AW(AW)) u_l2_cmp (
    .vld         (l2_cmp_vld_q && L2RdValid_DI),
    .entry_start (l2_entry_start),
    .entry_end   (l2_entry_end),
    .range_start (range_start_q),
    .range_end   (range_end_q),
    .hit         (l2_hit)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q       <= ST_IDLE;
      range_start_q <= '0;
      range_end_q   <= '0;
      l1_idx_q      <= '0;
      l2_idx_q      <= '0;
      l1_cmp_idx_q  <= '0;
      l2_cmp_idx_q  <= '0;
      l1_rd_en_q    <= 1'b0;
      l2_rd_en_q    <= 1'b0;
      l1_cmp_vld_q  <= 1'b0;
      l2_cmp_vld_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      err_q        <= InvReq_SI && (state_q != ST_IDLE);
      l1_cmp_vld_q <= l1_rd_en_q;
      l1_cmp_idx_q <= l1_idx_q;
      // An ungranted L2 read returns nothing, so it must not be compared.
      l2_cmp_vld_q <= l2_rd_en_q && L2Gnt_SI;
      l2_cmp_idx_q <= l2_idx_q;

      case (state_q)
        ST_IDLE: begin
          if (InvReq_SI) begin
            range_start_q <= InvStart_DI;
            range_end_q   <= InvEnd_DI;
            if (InvStart_DI > InvEnd_DI) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_L1_SCAN;
              busy_q     <= 1'b1;
              l1_rd_en_q <= 1'b1;
              l1_idx_q   <= '0;
            end
          end
        end
        ST_L1_SCAN: begin
          if (l1_idx_q == L1_LAST) begin
            state_q    <= ST_L2_SCAN;
            l1_rd_en_q <= 1'b0;
            l1_idx_q   <= '0;
            l2_rd_en_q <= 1'b1;
            l2_idx_q   <= '0;
          end else begin
            l1_idx_q <= l1_idx_q + L1_IW'(1);
          end
        end
        ST_L2_SCAN: begin
          if (L2Gnt_SI) begin
            if (l2_idx_q == L2_LAST) begin
              state_q    <= ST_DRAIN;
              l2_rd_en_q <= 1'b0;
              l2_idx_q   <= '0;
            end else begin
              l2_idx_q <= l2_idx_q + L2_IW'(1);
            end
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign Busy_SO     = busy_q;
  assign Done_SO     = done_q;
  assign ReqErr_SO   = err_q;
  assign L1RdEn_SO   = l1_rd_en_q;
  assign L1RdIdx_DO  = l1_idx_q;
  assign L2RdEn_SO   = l2_rd_en_q;
  assign L2RdIdx_DO  = l2_idx_q;
  assign L1ClrEn_SO  = l1_hit;
  assign L1ClrIdx_DO = l1_cmp_idx_q;
  assign L2ClrEn_SO  = l2_hit;
  assign L2ClrIdx_DO = l2_cmp_idx_q;

endmodule
